// File: rtl/ms_arbiter.sv
// ms_arbiter: two-requester round-robin write arbiter driving a single slave port.
// Optional XFER timeout is enabled by defining ARB_TIMEOUT_EN (parameter TO_CYCLES).
// Without ARB_TIMEOUT_EN a transfer waits for s_ready indefinitely and err0/err1 stay 0.
module ms_arbiter #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TO_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              s_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state, state_nxt;
    logic              rr, rr_nxt;
    logic              gnt0_nxt, gnt1_nxt;
    logic              done0_nxt, done1_nxt;
    logic              err0_nxt, err1_nxt;
    logic              m_valid_nxt;
    logic [ADDR_W-1:0] m_addr_nxt;
    logic [DATA_W-1:0] m_data_nxt;
    logic              sel;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TO_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
`else
    logic unused_to_cycles;
    assign unused_to_cycles = (TO_CYCLES != 0);
`endif

    // Requester selection: rr breaks ties only when both are requesting.
    assign sel = (req0 && req1) ? rr : req1;

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr      <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
`ifdef ARB_TIMEOUT_EN
            to_cnt  <= '0;
`endif
        end else begin
            state   <= state_nxt;
            rr      <= rr_nxt;
            gnt0    <= gnt0_nxt;
            gnt1    <= gnt1_nxt;
            done0   <= done0_nxt;
            done1   <= done1_nxt;
            err0    <= err0_nxt;
            err1    <= err1_nxt;
            m_valid <= m_valid_nxt;
            m_addr  <= m_addr_nxt;
            m_data  <= m_data_nxt;
`ifdef ARB_TIMEOUT_EN
            to_cnt  <= to_cnt_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        rr_nxt      = rr;
        gnt0_nxt    = gnt0;
        gnt1_nxt    = gnt1;
        done0_nxt   = 1'b0;
        done1_nxt   = 1'b0;
        err0_nxt    = 1'b0;
        err1_nxt    = 1'b0;
        m_valid_nxt = 1'b0;
        m_addr_nxt  = m_addr;
        m_data_nxt  = m_data;
`ifdef ARB_TIMEOUT_EN
        to_cnt_nxt  = to_cnt;
`endif
        case (state)
            IDLE: begin
                gnt0_nxt = 1'b0;
                gnt1_nxt = 1'b0;
                if (req0 || req1) begin
                    state_nxt   = XFER;
                    gnt0_nxt    = ~sel;
                    gnt1_nxt    = sel;
                    m_valid_nxt = 1'b1;
                    m_addr_nxt  = sel ? addr1 : addr0;
                    m_data_nxt  = sel ? data1 : data0;
`ifdef ARB_TIMEOUT_EN
                    to_cnt_nxt  = '0;
`endif
                end
            end
            XFER: begin
                m_valid_nxt = 1'b1;
                if (s_ready) begin
                    // Accepted: pulse done, hand priority to the other requester.
                    state_nxt   = DONE;
                    m_valid_nxt = 1'b0;
                    done0_nxt   = gnt0;
                    done1_nxt   = gnt1;
                    rr_nxt      = gnt0;
`ifdef ARB_TIMEOUT_EN
                end else if (to_cnt == CNT_W'(TO_CYCLES - 1)) begin
                    // Slave never answered: end the transfer with an error.
                    state_nxt   = DONE;
                    m_valid_nxt = 1'b0;
                    done0_nxt   = gnt0;
                    done1_nxt   = gnt1;
                    err0_nxt    = gnt0;
                    err1_nxt    = gnt1;
                    rr_nxt      = gnt0;
                    to_cnt_nxt  = CNT_W'(TO_CYCLES);
                end else begin
                    to_cnt_nxt  = to_cnt + CNT_W'(1);
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
                gnt0_nxt  = 1'b0;
                gnt1_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                gnt0_nxt  = 1'b0;
                gnt1_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ms_arbiter.sv
// Directed bench for ms_arbiter: reset, contention/round-robin, single request,
// backpressure with held-off request, mid-transfer reset, timeout (or its absence).
module tb_ms_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, s_ready;
    logic [3:0] addr0, addr1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, done0, done1, err0, err1, m_valid;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    logic [6:0] ctl;

    int tests  = 0;
    int failed = 0;

    // {gnt0, gnt1, done0, done1, err0, err1, m_valid}
    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_X0   = 7'b1000001;
    localparam logic [6:0] C_X1   = 7'b0100001;
    localparam logic [6:0] C_D0   = 7'b1010000;
    localparam logic [6:0] C_D1   = 7'b0101000;
    localparam logic [6:0] C_TO0  = 7'b1010100;

    ms_arbiter #(.ADDR_W(4), .DATA_W(8), .TO_CYCLES(15)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .err0(err0), .err1(err1),
        .m_addr(m_addr), .m_data(m_data), .m_valid(m_valid),
        .s_ready(s_ready)
    );

    assign ctl = {gnt0, gnt1, done0, done1, err0, err1, m_valid};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Grants must be mutually exclusive at all times.
    always @(negedge clk) begin
        chk("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
    end

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; s_ready = 1'b0;
        addr0 = 4'd0; addr1 = 4'd0; data0 = 8'd0; data1 = 8'd0;
        tick(); tick();
        chk("rst_ctl",  32'(ctl), 32'(C_IDLE));
        chk("rst_addr", 32'(m_addr), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);

        // Contention straight out of reset: rr=0 favours requester 0.
        rst = 1'b0;
        req0 = 1'b1; addr0 = 4'd1; data0 = 8'h11;
        req1 = 1'b1; addr1 = 4'd3; data1 = 8'h22;
        s_ready = 1'b1;
        tick(); chk("cont_g0", 32'(ctl), 32'(C_X0));
        chk("cont_a0", 32'(m_addr), 32'd1);
        chk("cont_d0", 32'(m_data), 32'h11);
        tick(); chk("cont_done0", 32'(ctl), 32'(C_D0));
        req0 = 1'b0;
        tick(); chk("cont_idle0", 32'(ctl), 32'(C_IDLE));
        tick(); chk("cont_g1", 32'(ctl), 32'(C_X1));
        chk("cont_a1", 32'(m_addr), 32'd3);
        chk("cont_d1", 32'(m_data), 32'h22);
        tick(); chk("cont_done1", 32'(ctl), 32'(C_D1));
        req1 = 1'b0;
        tick(); chk("cont_idle1", 32'(ctl), 32'(C_IDLE));
        // Re-raise both: rr points back at requester 0.
        req0 = 1'b1; req1 = 1'b1;
        tick(); chk("rr_g0", 32'(ctl), 32'(C_X0));
        tick(); chk("rr_done0", 32'(ctl), 32'(C_D0));
        req0 = 1'b0;
        tick(); chk("rr_idle0", 32'(ctl), 32'(C_IDLE));
        tick(); chk("rr_g1", 32'(ctl), 32'(C_X1));
        tick(); chk("rr_done1", 32'(ctl), 32'(C_D1));
        req1 = 1'b0;
        tick(); chk("rr_idle1", 32'(ctl), 32'(C_IDLE));

        // Lone req1 while rr=0: granted anyway.
        req1 = 1'b1; addr1 = 4'd6; data1 = 8'h66;
        tick(); chk("lone1_g", 32'(ctl), 32'(C_X1));
        chk("lone1_a", 32'(m_addr), 32'd6);
        tick(); chk("lone1_done", 32'(ctl), 32'(C_D1));
        req1 = 1'b0;
        tick(); chk("lone1_idle", 32'(ctl), 32'(C_IDLE));

        // Single request vector: 3 cycles, one m_valid cycle.
        req0 = 1'b1; addr0 = 4'd2; data0 = 8'h5A;
        tick(); chk("single_g", 32'(ctl), 32'(C_X0));
        chk("single_a", 32'(m_addr), 32'd2);
        chk("single_d", 32'(m_data), 32'h5A);
        tick(); chk("single_done", 32'(ctl), 32'(C_D0));
        chk("single_a_hold", 32'(m_addr), 32'd2);
        req0 = 1'b0;
        tick(); chk("single_idle", 32'(ctl), 32'(C_IDLE));

        // Backpressure: rr=1 but only req0 asks; req1 arrives mid-XFER and req0 drops.
        req0 = 1'b1; addr0 = 4'd7; data0 = 8'hA5; s_ready = 1'b0;
        tick(); chk("bp_g", 32'(ctl), 32'(C_X0));
        for (int i = 0; i < 4; i++) begin
            if (i == 1) req1 = 1'b1;
            if (i == 2) req0 = 1'b0;
            tick();
            chk("bp_hold_ctl", 32'(ctl), 32'(C_X0));
            chk("bp_hold_a", 32'(m_addr), 32'd7);
            chk("bp_hold_d", 32'(m_data), 32'hA5);
        end
        s_ready = 1'b1;
        tick(); chk("bp_done", 32'(ctl), 32'(C_D0));
        tick(); chk("bp_idle", 32'(ctl), 32'(C_IDLE));
        tick(); chk("held_g1", 32'(ctl), 32'(C_X1));
        tick(); chk("held_done1", 32'(ctl), 32'(C_D1));
        req1 = 1'b0;
        tick(); chk("held_idle", 32'(ctl), 32'(C_IDLE));

        // Reset in the middle of XFER.
        req1 = 1'b1; addr1 = 4'd9; data1 = 8'hC3; s_ready = 1'b0;
        tick(); chk("mr_g1", 32'(ctl), 32'(C_X1));
        #2 rst = 1'b1;
        #1 chk("mr_async_ctl", 32'(ctl), 32'(C_IDLE));
        chk("mr_async_a", 32'(m_addr), 32'd0);
        chk("mr_async_d", 32'(m_data), 32'd0);
        s_ready = 1'b1;
        tick(); chk("mr_held_ctl", 32'(ctl), 32'(C_IDLE));
        rst = 1'b0;
        tick(); chk("mr_regrant", 32'(ctl), 32'(C_X1));
        chk("mr_regrant_a", 32'(m_addr), 32'd9);
        tick(); chk("mr_done1", 32'(ctl), 32'(C_D1));
        req1 = 1'b0;
        tick(); chk("mr_idle", 32'(ctl), 32'(C_IDLE));

        // Slave never ready.
        req0 = 1'b1; addr0 = 4'd4; data0 = 8'h44; s_ready = 1'b0;
        tick(); chk("to_g", 32'(ctl), 32'(C_X0));
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 14; i++) begin
            tick(); chk("to_wait", 32'(ctl), 32'(C_X0));
        end
        tick(); chk("to_err", 32'(ctl), 32'(C_TO0));
        req0 = 1'b0;
        tick(); chk("to_idle", 32'(ctl), 32'(C_IDLE));
`else
        for (int i = 0; i < 105; i++) begin
            tick(); chk("noto_wait", 32'(ctl), 32'(C_X0));
        end
        s_ready = 1'b1;
        tick(); chk("noto_done", 32'(ctl), 32'(C_D0));
        req0 = 1'b0;
        tick(); chk("noto_idle", 32'(ctl), 32'(C_IDLE));
        chk("noto_unused", 32'(C_TO0 & 7'b0000100), 32'h4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ms_arbiter.md
MS_ARBITER -- requirements
Module: ms_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4: slave register address width.
REQ-002 Parameter DATA_W, default 8: write data width.
REQ-003 Parameter TO_CYCLES, default 15: timeout limit in cycles; used only when ARB_TIMEOUT_EN is defined.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req0, req1  input  1 each  write request from requester 0 / 1; held high until that requester's done pulse.
REQ-007 addr0, addr1  input  ADDR_W each  target register address; held stable while req is high.
REQ-008 data0, data1  input  DATA_W each  write data; held stable while req is high.
REQ-009 gnt0, gnt1  output  1 each  requester owns the slave.
REQ-010 done0, done1  output  1 each  one-cycle pulse: the transfer has ended.
REQ-011 err0, err1  output  1 each  qualifies done: the transfer timed out.
REQ-012 m_addr  output  ADDR_W  address driven to the slave.
REQ-013 m_data  output  DATA_W  data driven to the slave.
REQ-014 m_valid  output  1  transfer active toward the slave.
REQ-015 s_ready  input  1  slave accepts the transfer; a transfer is complete when m_valid and s_ready are both high on a clk edge.

Function
REQ-016 The FSM SHALL have three states: IDLE, XFER, DONE.
REQ-017 IDLE with no req high: stay in IDLE.
REQ-018 IDLE with any req high: grant one requester, register its addr/data into m_addr/m_data, assert its gnt, go to XFER.
REQ-019 Arbitration SHALL be round-robin with pointer rr.
  - Both req high: grant the requester rr selects.
  - One req high: grant it regardless of rr.
REQ-020 rr SHALL point to the non-granted requester after every DONE; rr = 0 after reset.
REQ-021 m_valid SHALL be high in XFER and low in every other state.
REQ-022 m_addr/m_data SHALL stay constant from grant until the return to IDLE.
REQ-023 XFER with s_ready = 1: go to DONE.
REQ-024 XFER with s_ready = 0: stay in XFER and hold m_valid.
REQ-025 DONE: pulse done of the granted requester for exactly one cycle, keep its gnt high, go to IDLE.
REQ-026 gnt SHALL drop on entry to IDLE.
REQ-027 In DONE, req inputs SHALL be ignored.
REQ-028 Timing: req sampled at edge N → m_valid high in cycle N+1 → done high in the cycle after the accepting edge. Minimum 3 cycles per transfer.
REQ-029 At most one gnt SHALL be high at any time; gnt0 & gnt1 never both high.
REQ-030 A req that drops during XFER SHALL NOT abort the transfer; it completes normally.
REQ-031 A request arriving during XFER or DONE SHALL be held off until IDLE.
REQ-032 err0/err1 SHALL be high only in the same cycle as the corresponding done.

Reset
REQ-033 Asserting rst SHALL immediately force IDLE, including mid-XFER (in-flight transfer abandoned, no done).
REQ-034 Reset values of outputs and state:
  - gnt0 = gnt1 = 0, done0 = done1 = 0, err0 = err1 = 0
  - m_valid = 0, m_addr = 0, m_data = 0
  - rr = 0, timeout counter = 0
REQ-035 The first arbitration SHALL occur on the first edge after rst deasserts.

Configuration
REQ-036 Macro ARB_TIMEOUT_EN defined: a counter SHALL operate as follows.
  - Clears on XFER entry; increments each XFER cycle with s_ready = 0.
  - On reaching TO_CYCLES: go to DONE, pulse done plus err of the granted requester, update rr as normal.
REQ-037 ARB_TIMEOUT_EN undefined: no counter; XFER waits indefinitely; err0/err1 tied to 0.

Verification
REQ-038 Single request: req0=1, addr0=2, data0=8'h5A, s_ready=1 → m_valid one cycle with m_addr=2, m_data=8'h5A; done0 pulse; total 3 cycles.
REQ-039 Contention: req0 and req1 high together from reset, s_ready=1 → req0 granted first, then req1; re-raise both → req0 is served next (rr alternates).
REQ-040 Backpressure: s_ready=0 for 4 cycles, then 1 → m_valid high 5 cycles with addr/data stable; done a cycle later; gnt0/gnt1 never both high.
REQ-041 Mid-transfer reset: rst asserted during XFER → all outputs reset values in the same cycle; no done; after release, a pending req1 is granted normally.
REQ-042 Timeout (ARB_TIMEOUT_EN, TO_CYCLES=15): s_ready held 0 → done0=1 and err0=1 after 15 XFER cycles; without the macro, m_valid stays high past 100 cycles and err0 stays 0.
